// File: rtl/apb_req_master.sv
// apb_req_master: bridges a req/gnt/rvalid core bus to one APB3 master port, one transfer per request.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/gnt_o/addr_i/we_i/wdata_i request side;
// rvalid_o/rdata_o/err_o response beat; psel_o/penable_o/pwrite_o/paddr_o/pwdata_o/prdata_i/pready_i/pslverr_i APB side.
// Optional macro APB_REQ_MASTER_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES cycles without pready_i.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_next;
  logic done, abort;
  assign done = state == ACCESS && pready_i;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !pready_i) cnt <= cnt + CW'(1);
  end
  // cnt counts earlier wait cycles, so this is the TIMEOUT_CYCLES-th ACCESS cycle still without pready_i
  assign abort = state == ACCESS && !pready_i && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state == IDLE   ? (req_i ? SETUP : IDLE) :
                 state == SETUP  ? ACCESS :
                 state == ACCESS ? ((done || abort) ? IDLE : ACCESS) : IDLE;
  end
  always_comb begin
    gnt_o     = state == IDLE && req_i;
    psel_o    = state == SETUP || state == ACCESS;
    penable_o = state == ACCESS;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= done || abort;
      if (gnt_o) begin
        paddr_o  <= addr_i;
        pwrite_o <= we_i;
        pwdata_o <= wdata_i;
      end
      if (done) begin
        rdata_o <= pwrite_o ? '0 : prdata_i;
        err_o   <= pslverr_i;
      end else if (abort) begin
        rdata_o <= '0;
        err_o   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: randomized transfers against a transaction-level model of the APB request bridge.
module tb_apb_req_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, req = 0, we = 0, pready = 0, pslverr = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0, prdata = '0;
  logic gnt, rvalid, err, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] rdata, pwdata;
  apb_req_master #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_tot = 0, cyc = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) cyc++;
  // APB slave: pready after wait_cfg wait cycles; response data only meaningful on the ready cycle
  int wait_cfg = 0, acc = 0;
  logic [DW-1:0] rd_cfg = '0;
  logic err_cfg = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (psel && penable) begin
      pready = acc == wait_cfg;
      prdata = pready ? rd_cfg : $urandom;
      pslverr = pready ? err_cfg : 1'($urandom);
      acc++;
    end else begin
      acc = 0;
      pready = 1'($urandom);
      prdata = $urandom;
      pslverr = 1'($urandom);
    end
  end
  // model: busy from the cycle after grant; k = cycles since grant (1 = SETUP, >=2 = ACCESS)
  bit busy = 0;
  int k = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rd = '0;
  logic m_we = 0, m_err = 0, m_rv = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; k = 0; m_addr = '0; m_we = 0; m_wdata = '0; m_rd = '0; m_err = 0; m_rv = 0;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
    end else begin
      chk("gnt", gnt, !busy && req);
      chk("psel", psel, busy);
      chk("penable", penable, busy && k >= 2);
      chk("paddr", paddr, m_addr);
      chk("pwrite", pwrite, m_we);
      chk("pwdata", pwdata, m_wdata);
      chk("rvalid", rvalid, m_rv);
      chk("rdata", rdata, m_rd);
      chk("err", err, m_err);
      m_rv = 0;
      if (busy) begin
        if (k >= 2 && pready) begin
          m_rd = m_we ? '0 : prdata; m_err = pslverr; m_rv = 1; busy = 0;
        end
`ifdef APB_REQ_MASTER_TIMEOUT_EN
        else if (k - 1 == TO) begin
          m_rd = '0; m_err = 1; m_rv = 1; busy = 0;
        end
`endif
        else k++;
      end else if (req) begin
        m_addr = addr; m_we = we; m_wdata = wdata; busy = 1; k = 1;
      end
    end
  end
  task automatic run(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input int waits,
                     input logic [DW-1:0] rd, input logic e, output int g_cyc, output int r_cyc,
                     output logic [DW-1:0] r_rdata, output logic r_err);
    bit got;
    wait_cfg = waits; rd_cfg = rd; err_cfg = e;
    addr = a; we = w; wdata = d; req = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt) begin got = 1; break; end
      @(posedge clk);
      #1;
    end
    chk("gnt_seen", got, 1);
    g_cyc = cyc;
    @(posedge clk);
    #1;
    req = 0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (rvalid) begin got = 1; break; end
    end
    chk("rvalid_seen", got, 1);
    r_cyc = cyc; r_rdata = rdata; r_err = err;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    int g, r, prev_r, waits, gap;
    logic [DW-1:0] rd;
    logic e;
    bit got;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    run(32'h1A10_2004, 0, '0, 0, 32'hDEAD_BEEF, 0, g, r, rd, e);
    chk("rd0_latency", r - g, 3);
    chk("rd0_rdata", rd, 32'hDEAD_BEEF);
    chk("rd0_err", e, 0);
    run(32'h1A10_3008, 1, 32'h0000_00A5, 3, 32'h1234_5678, 0, g, r, rd, e);
    chk("wr3_latency", r - g, 6);
    chk("wr3_rdata", rd, 0);
    chk("wr3_err", e, 0);
    run(32'h1A10_400C, 0, '0, 1, 32'hCAFE_F00D, 1, g, r, rd, e);
    chk("slverr_latency", r - g, 4);
    chk("slverr_rdata", rd, 32'hCAFE_F00D);
    chk("slverr_err", e, 1);
    run(32'h0000_0010, 0, '0, 0, 32'h1111_1111, 0, g, prev_r, rd, e);
    run(32'h0000_0020, 1, 32'h2222_2222, 0, 32'h3333_3333, 0, g, r, rd, e);
    chk("b2b_gnt_cycle", g, prev_r);
    chk("b2b_latency", r - g, 3);
    prev_r = r;
    for (int n = 0; n < 150; n++) begin
      gap = $urandom_range(0, 2);
      waits = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      run($urandom, 1'($urandom), $urandom, waits, $urandom, 1'($urandom), g, r, rd, e);
      if (gap == 0) chk("rand_b2b_gnt", g, prev_r);
      chk("rand_latency", r - g, 3 + waits);
      prev_r = r;
    end
    wait_cfg = 1000; addr = 32'h0BAD_0000; we = 0; wdata = '0; req = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt) begin got = 1; break; end
      @(posedge clk);
      #1;
    end
    chk("rst_test_gnt", got, 1);
    @(posedge clk);
    #1;
    req = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_test_in_access", penable, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_psel_drop", psel, 0);
    chk("async_penable_drop", penable, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("no_rvalid_after_rst", rvalid, 0);
    end
    run(32'h1A10_5000, 0, '0, 0, 32'h7777_0001, 0, g, r, rd, e);
    chk("post_rst_latency", r - g, 3);
    chk("post_rst_rdata", rd, 32'h7777_0001);
`ifdef APB_REQ_MASTER_TIMEOUT_EN
    run(32'h1A10_6000, 0, '0, 1000, 32'hFFFF_FFFF, 0, g, r, rd, e);
    chk("timeout_latency", r - g, 2 + TO);
    chk("timeout_err", e, 1);
    chk("timeout_rdata", rd, 0);
    run(32'h1A10_7000, 0, '0, TO - 1, 32'h0000_005A, 0, g, r, rd, e);
    chk("edge_ready_latency", r - g, 2 + TO);
    chk("edge_ready_err", e, 0);
    chk("edge_ready_rdata", rd, 32'h0000_005A);
`endif
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
